pipe_stage_buffer: RTL and testbench

- Parametrised successor to the fixed per-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS datapath.
- Carries LANES independent WIDTH-bit fields with a valid/ready handshake, stall (hold) and flush (bubble insertion).
- Keeps a saturating bubble counter for performance monitoring.
- One instance per stage boundary replaces the four hand-written buffers.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_stage_buffer.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers and their performance counters.
// No logic; constants and types only.
// Imported by pipe_stage_buffer and pipe_sat_counter users.
package pipe_pkg;

    // MIPS canonical NOP encoding (sll $0,$0,0)
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Default lane width of the MIPS datapath
    localparam int WORD_W = 32;

    // Occupancy of a stage that carries an optional skid entry
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter for performance monitoring.
// Count reflects an inc one cycle after it is sampled.
// No backpressure; sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on each inc until all-ones, then hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Generic pipeline stage register: LANES x WIDTH fields, valid/ready, stall, flush, bubble counter.
// One cycle from accepted in_data to out_data/out_valid; only in_ready is combinational.
// Backpressure via out_ready; define PIPE_STAGE_SKID_EN for a skid entry that makes in_ready independent of out_ready.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int          WIDTH   = WORD_W,
    parameter int          LANES   = 6,
    parameter logic [31:0] NOP_VAL = MIPS_NOP,
    parameter int          CNT_W   = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       bubble_cnt
);

    localparam int                 BUS_W    = LANES * WIDTH;
    localparam logic [WIDTH-1:0]   NOP_LANE = WIDTH'(NOP_VAL);
    localparam logic [BUS_W-1:0]   NOP_BUS  = {LANES{NOP_LANE}};

    logic acc;
    logic con;

    // Flush squashes the upstream beat, so it never counts as accepted
    assign acc = in_valid && in_ready && !flush;
    assign con = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic [BUS_W-1:0] main_q;
    logic [BUS_W-1:0] skid_q;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Ready depends only on registered occupancy, breaking the out_ready path
    assign in_ready  = !stall && (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    // Next occupancy and which register takes which beat
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && !con) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (con && !acc) begin
                        state_d = ST_EMPTY;
                    end else if (acc && con) begin
                        load_main_in = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (con) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main and skid data; main keeps its value when drained so data is held, not cleared
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_q <= NOP_BUS;
            skid_q <= NOP_BUS;
        end else if (flush) begin
            main_q <= NOP_BUS;
            skid_q <= NOP_BUS;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end else if (load_main_skid) begin
                skid_q <= NOP_BUS;
            end
        end
    end

`else

    // Accept when not stalled and the register is empty or draining this cycle
    assign in_ready = !stall && (!out_valid || out_ready);

    // Single stage register: flush > accept > consume > hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_data  <= NOP_BUS;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= NOP_BUS;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (con) begin
            out_valid <= 1'b0;
        end
    end

`endif

    // A bubble is downstream asking for a beat that is not there; flush cycles excluded
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (out_ready && !out_valid && !flush),
        .cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: directed scenarios plus random traffic vs a queue model.
// Inputs driven after the falling edge; outputs sampled 1ns later, well away from the rising edge.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_pipe_stage_buffer;

    localparam int WIDTH = 32;
    localparam int LANES = 6;
    localparam int BUS_W = WIDTH * LANES;
    localparam logic [BUS_W-1:0] NOP_BUS = '0;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             CLK;
    logic             RST_N;
    logic             in_valid;
    logic             in_ready;
    logic             in_ready_s;
    logic [BUS_W-1:0] in_data;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic             out_valid_s;
    logic             out_ready;
    logic [BUS_W-1:0] out_data;
    logic [BUS_W-1:0] out_data_s;
    logic [15:0]      bubble_cnt;
    logic [3:0]       bubble_cnt_s;

    int errors = 0;
    int checks = 0;

    // Reference model: beats held by the stage in order, value shown when empty, bubble tally
    logic [BUS_W-1:0] mq[$];
    logic [BUS_W-1:0] held;
    int               bub;

    pipe_stage_buffer #(
        .WIDTH (WIDTH), .LANES (LANES), .NOP_VAL (32'h0000_0000), .CNT_W (16)
    ) dut (
        .CLK (CLK), .RST_N (RST_N), .in_valid (in_valid), .in_ready (in_ready),
        .in_data (in_data), .stall (stall), .flush (flush), .out_valid (out_valid),
        .out_ready (out_ready), .out_data (out_data), .bubble_cnt (bubble_cnt)
    );

    pipe_stage_buffer #(
        .WIDTH (WIDTH), .LANES (LANES), .NOP_VAL (32'h0000_0000), .CNT_W (4)
    ) dut_s (
        .CLK (CLK), .RST_N (RST_N), .in_valid (in_valid), .in_ready (in_ready_s),
        .in_data (in_data), .stall (stall), .flush (flush), .out_valid (out_valid_s),
        .out_ready (out_ready), .out_data (out_data_s), .bubble_cnt (bubble_cnt_s)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] rnd_bus();
        logic [BUS_W-1:0] b;
        for (int k = 0; k < LANES; k++) b[k*WIDTH +: WIDTH] = $urandom;
        return b;
    endfunction

    function automatic logic model_ready(input logic st, input logic ordy);
        if (SKID) return !st && (mq.size() < 2);
        return !st && (mq.size() == 0 || ordy);
    endfunction

    // Compare every output of both instances against the model
    task automatic check_now();
        logic             ev;
        logic [BUS_W-1:0] ed;
        logic             er;
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : held;
        er = model_ready(stall, out_ready);
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("in_ready", in_ready, er);
        chk("bubble_cnt", bubble_cnt, (bub > 65535) ? 65535 : bub);
        chk("out_valid_s", out_valid_s, ev);
        chk("out_data_s", out_data_s, ed);
        chk("in_ready_s", in_ready_s, er);
        chk("bubble_cnt_s", bubble_cnt_s, (bub > 15) ? 15 : bub);
    endtask

    task automatic model_reset();
        mq.delete();
        held = NOP_BUS;
        bub  = 0;
    endtask

    // One clock cycle: drive, check, then advance the model for the coming rising edge
    task automatic cyc(input logic v, input logic [BUS_W-1:0] d, input logic st,
                       input logic fl, input logic ordy, output logic accepted);
        logic a;
        logic c;
        @(negedge CLK);
        in_valid  = v;
        in_data   = d;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        #1;
        check_now();
        a = 1'b0;
        if (fl) begin
            mq.delete();
            held = NOP_BUS;
        end else begin
            if (ordy && mq.size() == 0) bub++;
            a = v && model_ready(st, ordy);
            c = (mq.size() > 0) && ordy;
            if (c) held = mq.pop_front();
            if (a) mq.push_back(d);
        end
        accepted = a;
    endtask

    logic             acc_o;
    logic             pend;
    logic [BUS_W-1:0] pend_d;
    logic [BUS_W-1:0] beat_a;
    logic [BUS_W-1:0] beat_b;

    initial begin
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_now();
        @(negedge CLK);
        RST_N = 1'b1;

        // Pass-through: three back-to-back beats with lane0 = 0x2010_0005
        for (int i = 0; i < 3; i++) begin
            beat_a = rnd_bus();
            beat_a[WIDTH-1:0] = 32'h2010_0005;
            cyc(1'b1, beat_a, 1'b0, 1'b0, 1'b1, acc_o);
        end
        cyc(1'b0, rnd_bus(), 1'b0, 1'b0, 1'b1, acc_o);

        // Stall for two cycles with downstream draining, then accept 0xAAAA_AAAA
        beat_a = {LANES{32'hAAAA_AAAA}};
        cyc(1'b1, beat_a, 1'b0, 1'b0, 1'b1, acc_o);
        cyc(1'b1, beat_a, 1'b1, 1'b0, 1'b1, acc_o);
        cyc(1'b1, beat_a, 1'b1, 1'b0, 1'b1, acc_o);
        cyc(1'b1, beat_a, 1'b0, 1'b0, 1'b1, acc_o);
        cyc(1'b0, rnd_bus(), 1'b0, 1'b0, 1'b1, acc_o);

        // Flush in the same cycle as an offered beat
        cyc(1'b1, rnd_bus(), 1'b0, 1'b0, 1'b0, acc_o);
        cyc(1'b1, rnd_bus(), 1'b0, 1'b1, 1'b1, acc_o);
        cyc(1'b0, rnd_bus(), 1'b0, 1'b0, 1'b0, acc_o);

        // Backpressure: hold 0x1234_5678, offer 0x9ABC_DEF0, then release in order
        beat_a = {LANES{32'h1234_5678}};
        beat_b = {LANES{32'h9ABC_DEF0}};
        cyc(1'b1, beat_a, 1'b0, 1'b0, 1'b0, acc_o);
        pend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(pend, beat_b, 1'b0, 1'b0, 1'b0, acc_o);
            if (acc_o) pend = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(pend, beat_b, 1'b0, 1'b0, 1'b1, acc_o);
            if (acc_o) pend = 1'b0;
        end

        // Idle with downstream ready: the 4-bit counter must stop at 0xF
        for (int i = 0; i < 20; i++) cyc(1'b0, rnd_bus(), 1'b0, 1'b0, 1'b1, acc_o);
        #1;
        chk("sat_small", bubble_cnt_s, 4'hF);

        // Random traffic; upstream holds a beat until accepted and drops it on flush
        pend = 1'b0;
        pend_d = '0;
        for (int i = 0; i < 400; i++) begin
            logic st;
            logic fl;
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend   = 1'b1;
                pend_d = rnd_bus();
            end
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 15) == 0);
            cyc(pend, pend_d, st, fl, ($urandom_range(0, 2) != 0), acc_o);
            if (acc_o || fl) pend = 1'b0;
        end

        // Asynchronous reset while a beat is held
        cyc(1'b1, rnd_bus(), 1'b0, 1'b0, 1'b0, acc_o);
        cyc(1'b0, rnd_bus(), 1'b0, 1'b0, 1'b0, acc_o);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_now();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, NOP_BUS);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(1'b1, rnd_bus(), 1'b0, 1'b0, 1'b1, acc_o);
        cyc(1'b0, rnd_bus(), 1'b0, 1'b0, 1'b1, acc_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
